// File: rtl/jts16_obj_scan_pkg.sv
// Shared definitions for the object-table scanner.
//   state_e     : scanner FSM states
//   W_*         : word index of each field inside an 8-word table entry
//   END_MARK    : bottom-row value that terminates the object list
//   dr_req_t    : draw request bundle handed to the draw stage
//   attr_word() : word fetched on each step of the attribute read burst
package jts16_obj_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_Y,
    ST_CHECK,
    ST_RD_ATTR,
    ST_WAIT_DR,
    ST_WRBACK,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [2:0] W_Y     = 3'd0; // {bottom, top}
  localparam logic [2:0] W_X     = 3'd1; // xpos
  localparam logic [2:0] W_PITCH = 3'd2; // {pitch, hflip at bit 8}
  localparam logic [2:0] W_OFF   = 3'd3; // start offset
  localparam logic [2:0] W_ATTR  = 3'd4; // {pal, prio, bank}
  localparam logic [2:0] W_ACC   = 3'd7; // line-offset accumulator

  localparam logic [7:0] END_MARK = 8'hFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  xpos;
    logic        hflip;
    logic [5:0]  pal;
    logic [1:0]  prio;
    logic [3:0]  bank;
  } dr_req_t;

  // Burst order: w1, w2, w3, w4, w7
  function automatic logic [2:0] attr_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return W_X;
      3'd1:    return W_PITCH;
      3'd2:    return W_OFF;
      3'd3:    return W_ATTR;
      default: return W_ACC;
    endcase
  endfunction

endpackage

// File: rtl/jts16_obj_scan_if.sv
// Bus bundle between the scanner, the object RAM and the draw stage.
//   tbl_addr/tbl_dout/tbl_we/tbl_din : object RAM port (read data one cycle late)
//   dr_start/dr_busy                 : draw request handshake
//   dr_addr..dr_bank                 : draw request fields
// master = scanner side, slave = RAM / draw stage side.
interface jts16_obj_scan_if;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        tbl_we;
  logic [15:0] tbl_din;
  logic        dr_start;
  logic        dr_busy;
  logic [15:0] dr_addr;
  logic [8:0]  dr_xpos;
  logic        dr_hflip;
  logic [5:0]  dr_pal;
  logic [1:0]  dr_prio;
  logic [3:0]  dr_bank;

  modport master (
    output tbl_addr, tbl_we, tbl_din,
    output dr_start, dr_addr, dr_xpos, dr_hflip, dr_pal, dr_prio, dr_bank,
    input  tbl_dout, dr_busy
  );

  modport slave (
    input  tbl_addr, tbl_we, tbl_din,
    input  dr_start, dr_addr, dr_xpos, dr_hflip, dr_pal, dr_prio, dr_bank,
    output tbl_dout, dr_busy
  );
endinterface

// File: rtl/jts16_obj_scan.sv
// Per-line object table scanner. On hstart it walks the object table,
// finds entries covering vrender, issues one draw request per visible
// entry and writes the advanced line offset back to word 7.
//   rst       : asynchronous active-high reset
//   clk       : clock
//   hstart    : line start pulse; starts (or restarts) a scan
//   vrender   : line being prepared
//   bus       : object RAM port and draw request handshake (master)
//   scan_done : high from end of scan until next hstart
module jts16_obj_scan
  import jts16_obj_scan_pkg::*;
#(
  parameter int unsigned MAXOBJ = 127,
  parameter int unsigned LW     = 8
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              hstart,
  input  logic [7:0]        vrender,
  jts16_obj_scan_if.master  bus,
  output logic              scan_done
);

  localparam int unsigned WB = $clog2(LW);

  state_e        state_q, state_d;
  logic [6:0]    entry_q, entry_d;
  logic [WB-1:0] word_q, word_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic [7:0]    pitch_q, pitch_d;
  logic [15:0]   off_q, off_d;
  dr_req_t       stg_q, stg_d;
  dr_req_t       dr_q, dr_d;
  logic          dr_start_q, dr_start_d;
  logic          we_q, we_d;
  logic [15:0]   din_q, din_d;
  logic          done_q, done_d;

  logic [7:0] top, bot;
  logic       visible;

  assign top     = bus.tbl_dout[7:0];
  assign bot     = bus.tbl_dout[15:8];
  // top == bot yields an empty range, so it is never visible
  assign visible = (top <= vrender) && (vrender < bot);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    pitch_d    = pitch_q;
    off_d      = off_q;
    stg_d      = stg_q;
    dr_d       = dr_q;
    dr_start_d = 1'b0;
    we_d       = 1'b0;
    din_d      = din_q;
    done_d     = done_q;

    // hstart wins over everything: it also drops a draw request or
    // writeback that would otherwise be issued this cycle
    if (hstart) begin
      state_d = ST_RD_Y;
      entry_d = '0;
      word_d  = WB'(W_Y);
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_RD_Y: state_d = ST_CHECK;
        ST_CHECK: begin
          if (bot == END_MARK) begin
            state_d = ST_DONE;
          end else if (visible) begin
            hit_d   = (vrender == top);
            cnt_d   = '0;
            word_d  = WB'(W_X);
            state_d = ST_RD_ATTR;
          end else begin
            state_d = ST_NEXT;
          end
        end
        ST_RD_ATTR: begin
          // address for step n is issued on step n-1; data lands one later
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < 3'd4) word_d = WB'(attr_word(cnt_q + 3'd1));
          case (cnt_q)
            3'd1: stg_d.xpos = bus.tbl_dout[8:0];
            3'd2: begin
              pitch_d     = bus.tbl_dout[15:8];
              stg_d.hflip = bus.tbl_dout[8];
            end
            3'd3: off_d = bus.tbl_dout;
            3'd4: begin
              stg_d.pal  = bus.tbl_dout[13:8];
              stg_d.prio = bus.tbl_dout[7:6];
              stg_d.bank = bus.tbl_dout[3:0];
            end
            3'd5: begin
              stg_d.addr = hit_q ? off_q
                                 : bus.tbl_dout + {{8{pitch_q[7]}}, pitch_q};
              state_d    = ST_WAIT_DR;
            end
            default: begin
            end
          endcase
        end
        ST_WAIT_DR: begin
          if (!bus.dr_busy) begin
            dr_start_d = 1'b1;
            dr_d       = stg_q;
            we_d       = 1'b1;
            din_d      = stg_q.addr;
            word_d     = WB'(W_ACC);
            state_d    = ST_WRBACK;
          end
        end
        ST_WRBACK: state_d = ST_NEXT;
        ST_NEXT: begin
          if (entry_q == 7'(MAXOBJ)) begin
            state_d = ST_DONE;
          end else begin
            entry_d = entry_q + 7'd1;
            word_d  = WB'(W_Y);
            state_d = ST_RD_Y;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      pitch_q    <= '0;
      off_q      <= '0;
      stg_q      <= '0;
      dr_q       <= '0;
      dr_start_q <= 1'b0;
      we_q       <= 1'b0;
      din_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      pitch_q    <= pitch_d;
      off_q      <= off_d;
      stg_q      <= stg_d;
      dr_q       <= dr_d;
      dr_start_q <= dr_start_d;
      we_q       <= we_d;
      din_q      <= din_d;
      done_q     <= done_d;
    end
  end

  assign bus.tbl_addr = {entry_q, word_q};
  assign bus.tbl_we   = we_q;
  assign bus.tbl_din  = din_q;
  assign bus.dr_start = dr_start_q;
  assign bus.dr_addr  = dr_q.addr;
  assign bus.dr_xpos  = dr_q.xpos;
  assign bus.dr_hflip = dr_q.hflip;
  assign bus.dr_pal   = dr_q.pal;
  assign bus.dr_prio  = dr_q.prio;
  assign bus.dr_bank  = dr_q.bank;
  assign scan_done    = done_q;

endmodule

// File: tb/tb_jts16_obj_scan.sv
module tb_jts16_obj_scan;
  localparam int unsigned MAXOBJ = 127;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hstart = 1'b0;
  logic [7:0] vrender = '0;
  logic       scan_done;

  jts16_obj_scan_if bus();

  jts16_obj_scan #(.MAXOBJ(MAXOBJ), .LW(8)) dut (
    .rst(rst), .clk(clk), .hstart(hstart), .vrender(vrender),
    .bus(bus), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // synchronous object RAM with a host load port
  logic [15:0] mem [0:1023];
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [15:0] host_data = '0;

  always @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_data;
    else if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_din;
    bus.tbl_dout <= mem[bus.tbl_addr];
  end

  // observed draw requests / writebacks
  logic [37:0] got_dr[$];
  logic [25:0] got_wr[$];
  int          e3_cnt = 0;

  always @(negedge clk) begin
    if (bus.dr_start)
      got_dr.push_back({bus.dr_addr, bus.dr_xpos, bus.dr_hflip,
                        bus.dr_pal, bus.dr_prio, bus.dr_bank});
    if (bus.tbl_we) got_wr.push_back({bus.tbl_addr, bus.tbl_din});
    if (bus.tbl_addr[9:3] == 7'd3) e3_cnt++;
  end

  // reference model state
  logic [15:0] ref_mem [0:1023];
  logic [37:0] exp_dr[$];
  logic [25:0] exp_wr[$];
  int          dr_base, wr_base;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    ref_mem[a] = d;
    host_addr  = 10'(a);
    host_data  = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  // Walk the table as the line renderer sees it: stop at the end marker,
  // emit a request for every entry whose row range covers vr.
  task automatic model_scan(input logic [7:0] vr);
    logic [15:0] w0, w2, w4, nv;
    exp_dr.delete();
    exp_wr.delete();
    for (int e = 0; e <= int'(MAXOBJ); e++) begin
      w0 = ref_mem[e*8];
      if (w0[15:8] == 8'hFF) break;
      if (w0[7:0] <= vr && vr < w0[15:8]) begin
        w2 = ref_mem[e*8+2];
        w4 = ref_mem[e*8+4];
        if (vr == w0[7:0]) nv = ref_mem[e*8+3];
        else nv = 16'((int'(ref_mem[e*8+7]) + int'($signed(w2[15:8]))) & 32'hFFFF);
        exp_dr.push_back({nv, ref_mem[e*8+1][8:0], w2[8], w4[13:8], w4[7:6], w4[3:0]});
        exp_wr.push_back({10'(e*8+7), nv});
      end
    end
  endtask

  task automatic start_scan(input logic [7:0] vr);
    vrender = vr;
    model_scan(vr);
    dr_base = got_dr.size();
    wr_base = got_wr.size();
    hstart  = 1'b1;
    @(negedge clk);
    hstart  = 1'b0;
  endtask

  task automatic finish_scan(input string tag);
    int n;
    for (int i = 0; i < 3000 && !scan_done; i++) @(negedge clk);
    chk({tag, ".done"}, scan_done, 1);
    chk({tag, ".ndr"}, got_dr.size() - dr_base, exp_dr.size());
    chk({tag, ".nwr"}, got_wr.size() - wr_base, exp_wr.size());
    n = (got_dr.size() - dr_base < exp_dr.size()) ? got_dr.size() - dr_base : exp_dr.size();
    for (int i = 0; i < n; i++) chk({tag, ".dr"}, got_dr[dr_base+i], exp_dr[i]);
    n = (got_wr.size() - wr_base < exp_wr.size()) ? got_wr.size() - wr_base : exp_wr.size();
    for (int i = 0; i < n; i++) chk({tag, ".wr"}, got_wr[wr_base+i], exp_wr[i]);
    foreach (exp_wr[i]) ref_mem[exp_wr[i][25:16]] = exp_wr[i][15:0];
  endtask

  initial begin
    int         e3_base, found, e;
    logic [7:0] t, b, vr;

    bus.dr_busy = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.addr",  bus.tbl_addr, 0);
    chk("rst.we",    bus.tbl_we, 0);
    chk("rst.din",   bus.tbl_din, 0);
    chk("rst.start", bus.dr_start, 0);
    chk("rst.draddr", bus.dr_addr, 0);
    chk("rst.fields", {bus.dr_xpos, bus.dr_hflip, bus.dr_pal, bus.dr_prio, bus.dr_bank}, 0);
    chk("rst.done",  scan_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // first visible line of entry 0 takes the start offset
    wr(0, 16'h2010); wr(1, 16'h0123); wr(2, 16'h0100); wr(3, 16'h1234);
    wr(4, 16'h2AC5); wr(7, 16'h5555); wr(8, 16'hFF00);
    start_scan(8'h10);
    finish_scan("first");
    chk("first.draddr", bus.dr_addr, 16'h1234);
    chk("first.wb", mem[7], 16'h1234);

    // later line: accumulator plus negative pitch
    wr(7, 16'h0100); wr(2, 16'hF800);
    start_scan(8'h11);
    finish_scan("pitch");
    chk("pitch.draddr", bus.dr_addr, 16'h00F8);
    chk("pitch.wb", mem[7], 16'h00F8);

    // end marker at entry 2: nothing beyond it is read
    wr(8, 16'h3020); wr(16, 16'hFF00);
    e3_base = e3_cnt;
    start_scan(8'h11);
    finish_scan("endmark");
    chk("endmark.e3", e3_cnt - e3_base, 0);

    // draw stage busy for 50 cycles
    bus.dr_busy = 1'b1;
    start_scan(8'h15);
    repeat (50) @(negedge clk);
    chk("busy.nodr", got_dr.size() - dr_base, 0);
    chk("busy.nowr", got_wr.size() - wr_base, 0);
    bus.dr_busy = 1'b0;
    finish_scan("busy");
    chk("busy.one", got_dr.size() - dr_base, 1);

    // hstart while reading attributes of entry 5
    for (int i = 0; i < 5; i++) wr(i*8, 16'h3020);
    wr(40, 16'h4000); wr(41, 16'h01AB); wr(42, 16'h0200); wr(43, 16'hBEEF);
    wr(44, 16'h3F7A); wr(47, 16'h1000); wr(48, 16'hFF00);
    start_scan(8'h05);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tbl_addr == 10'd41) begin found = 1; break; end
    end
    chk("abort.reach", found, 1);
    hstart = 1'b1;
    @(negedge clk);
    hstart = 1'b0;
    chk("abort.addr", bus.tbl_addr, 0);
    chk("abort.nowr", got_wr.size() - wr_base, 0);
    finish_scan("abort");

    // reset while a request is pending
    wr(0, 16'h4000); wr(8, 16'hFF00);
    bus.dr_busy = 1'b1;
    start_scan(8'h05);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.addr", bus.tbl_addr, 0);
    chk("midrst.we", bus.tbl_we, 0);
    chk("midrst.draddr", bus.dr_addr, 0);
    @(negedge clk);
    bus.dr_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst.nowr", got_wr.size() - wr_base, 0);
    chk("midrst.nodr", got_dr.size() - dr_base, 0);
    chk("midrst.done", scan_done, 0);

    // every entry visible, no end marker
    for (int i = 0; i <= int'(MAXOBJ); i++) begin
      wr(i*8, 16'hF000);
      wr(i*8+1, 16'($urandom)); wr(i*8+2, 16'($urandom)); wr(i*8+3, 16'($urandom));
      wr(i*8+4, 16'($urandom)); wr(i*8+7, 16'($urandom));
    end
    start_scan(8'h05);
    finish_scan("all");
    chk("all.count", got_dr.size() - dr_base, 128);

    // randomized tables around a random line
    for (int it = 0; it < 3; it++) begin
      vr = 8'($urandom_range(8, 247));
      for (int i = 0; i <= int'(MAXOBJ); i++) begin
        t = vr - 8'($urandom_range(0, 3));
        b = t + 8'($urandom_range(0, 8));
        if (b == 8'hFF) b = 8'hFE;
        wr(i*8, {b, t});
        wr(i*8+2, 16'($urandom));
      end
      if (it == 2) begin
        e = $urandom_range(20, 100);
        wr(e*8, 16'hFF00);
      end
      start_scan(vr);
      finish_scan("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jts16_obj_scan.md
JTS16_OBJ_SCAN -- requirements
Module: jts16_obj_scan

Interface
REQ-001 SHALL have parameters: MAXOBJ, default 127, last table entry index scanned; LW, default 8, table entry length in words (fixed).
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have ports: hstart  in  1  one-cycle pulse at line start; starts a scan.
REQ-005 SHALL have ports: vrender  in  8  line being prepared.
REQ-006 SHALL have ports: tbl_addr  out  10  object RAM word address; bits [9:3] entry, [2:0] word.
REQ-007 SHALL have ports: tbl_dout  in  16  object RAM read data, valid one cycle after tbl_addr.
REQ-008 SHALL have ports: tbl_we  out  1  object RAM write strobe, both bytes.
REQ-009 SHALL have ports: tbl_din  out  16  object RAM write data.
REQ-010 SHALL have ports: dr_start  out  1  one-cycle pulse; draw request fields valid.
REQ-011 SHALL have ports: dr_busy  in  1  draw stage busy; no dr_start while high.
REQ-012 SHALL have ports: dr_addr  out  16  ROM line offset for the sprite row.
REQ-013 SHALL have ports: dr_xpos  out  9  horizontal start position.
REQ-014 SHALL have ports: dr_hflip  out  1  horizontal flip.
REQ-015 SHALL have ports: dr_pal  out  6  palette.
REQ-016 SHALL have ports: dr_prio  out  2  priority.
REQ-017 SHALL have ports: dr_bank  out  4  ROM bank.
REQ-018 SHALL have ports: scan_done  out  1  high from end of scan until next hstart.

Function
REQ-019 Entry layout SHALL be: w0 = {bottom[15:8], top[7:0]}; w1[8:0] = xpos; w2 = {pitch[15:8] signed, hflip[8]}; w3 = start offset; w4 = {pal[13:8], prio[7:6], bank[3:0]}; w7 = line-offset accumulator.
REQ-020 States SHALL be IDLE, RD_Y, CHECK, RD_ATTR, WAIT_DR, WRBACK, NEXT, DONE.
REQ-021 IDLE SHALL wait for hstart, then clear entry counter and enter RD_Y with tbl_addr = {entry, 3'd0}.
REQ-022 CHECK SHALL use tbl_dout one cycle after address; bottom == 8'hFF SHALL end the list (go DONE).
REQ-023 Entry SHALL be visible when top <= vrender < bottom (8-bit unsigned); top == bottom SHALL be invisible; not visible SHALL go NEXT.
REQ-024 RD_ATTR SHALL read w1, w2, w3, w4, w7 in order, one word per cycle, pipelined, 6 cycles total.
REQ-025 New offset SHALL be w3 if vrender == top, else w7 + sign-extended pitch, modulo 2^16.
REQ-026 WAIT_DR SHALL hold while dr_busy; with dr_busy low, one dr_start pulse SHALL be emitted with dr_addr = new offset and all fields registered and stable until the next dr_start.
REQ-027 WRBACK SHALL assert tbl_we for exactly one cycle at {entry, 3'd7} with tbl_din = new offset.
REQ-028 NEXT SHALL increment entry; after entry MAXOBJ it SHALL go DONE; entry counter SHALL not wrap.
REQ-029 DONE SHALL set scan_done and return to IDLE; hstart in any non-IDLE state SHALL abort the scan and restart at entry 0 with no writeback for the aborted entry.
REQ-030 hstart arriving together with a pending dr_start SHALL suppress that dr_start.
REQ-031 tbl_we SHALL be low in every state except WRBACK.

Reset
REQ-032 On rst, state SHALL be IDLE and tbl_addr = 0, tbl_we = 0, tbl_din = 0, dr_start = 0, all dr_* fields = 0, scan_done = 0.
REQ-033 rst asserted mid-scan SHALL act immediately; no partial writeback SHALL complete.

Structure
REQ-034 Entry word indices, the end marker 8'hFF and the state encoding SHALL live in the shared jts16 package.
REQ-035 The block SHALL be a single module; no sub-module.

Verification
REQ-036 Entry 0 with w0 = 16'h2010 and vrender = 8'h10: expect dr_addr = w3 and w7 written with w3.
REQ-037 Same entry with vrender = 8'h11, w7 = 16'h0100, pitch = 8'hF8: expect dr_addr = 16'h00F8 and writeback 16'h00F8.
REQ-038 Entry 2 with w0 = 16'hFF00: expect scan_done after entry 2 and no reads of entry 3.
REQ-039 dr_busy held high 50 cycles: expect no dr_start, then exactly one pulse after release.
REQ-040 hstart during RD_ATTR of entry 5: expect no tbl_we and tbl_addr back to 0.
REQ-041 All 128 entries visible with dr_busy = 0: expect 128 dr_start pulses and 128 writebacks, then scan_done.
